norm_rr_scheduler: RTL and testbench

- Shares one normalization datapath between REQ_N requesters, each with its own valid/ready port.
- Datapath: leading-zero count, left shift, exponent adjust.
- Round-robin arbitration admits one operand per cycle into a 2-stage pipeline. The result returns with the requester id and zero/underflow flags.
- Sits between the arithmetic units and the floating-point packing logic.

---
 rtl/norm_pkg.sv | 21 ++
 rtl/leading_zero_counter.sv | 25 ++
 rtl/rr_arbiter.sv | 60 ++++++
 rtl/norm_rr_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_norm_rr_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/norm_pkg.sv
// norm_pkg: shared constants and types for the normalization scheduler.
//   DATA_W / EXP_W / REQ_N : default mantissa width, exponent width, requester count
//   ID_W                   : requester id width for the default configuration
//   LZ_W                   : leading-zero count width, wide enough to hold DATA_W itself
//   stage_t                : S1 payload {data, exp, id, lz} at the default widths
package norm_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned EXP_W  = 6;
    localparam int unsigned REQ_N  = 4;
    localparam int unsigned ID_W   = $clog2(REQ_N);
    localparam int unsigned LZ_W   = $clog2(DATA_W) + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [EXP_W-1:0]  exp;
        logic [ID_W-1:0]   id;
        logic [LZ_W-1:0]   lz;
    } stage_t;

endpackage

// File: rtl/leading_zero_counter.sv
// leading_zero_counter: combinational count of leading zeros of a mantissa.
//   data_i  : mantissa
//   count_o : number of leading zeros; equals DATA_W when data_i is zero
module leading_zero_counter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LZ_W   = $clog2(DATA_W) + 1
) (
    input  logic [DATA_W-1:0] data_i,
    output logic [LZ_W-1:0]   count_o
);

    logic found;

    always_comb begin
        count_o = LZ_W'(DATA_W);
        found   = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (!found && data_i[i]) begin
                count_o = LZ_W'(DATA_W - 1 - i);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a registered priority pointer.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset, pointer returns to 0
//   req_i     : request vector
//   advance_i : the current grant is being taken this cycle
//   grant_o   : one-hot grant (all zero when nothing requests)
//   idx_o     : encoded index of the granted requester
//   valid_o   : some requester is granted
module rr_arbiter #(
    parameter int unsigned REQ_N = 4,
    parameter int unsigned ID_W  = $clog2(REQ_N)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REQ_N-1:0] req_i,
    input  logic             advance_i,
    output logic [REQ_N-1:0] grant_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             valid_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;

    // Two passes: indices at or above the pointer first, then the wrapped-around rest.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < REQ_N; i++) begin
            if (!valid_o && req_i[i] && (ID_W'(i) >= ptr_q)) begin
                grant_o[i] = 1'b1;
                idx_o      = ID_W'(i);
                valid_o    = 1'b1;
            end
        end
        for (int i = 0; i < REQ_N; i++) begin
            if (!valid_o && req_i[i] && (ID_W'(i) < ptr_q)) begin
                grant_o[i] = 1'b1;
                idx_o      = ID_W'(i);
                valid_o    = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && valid_o) begin
            ptr_d = (idx_o == ID_W'(REQ_N - 1)) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/norm_rr_scheduler.sv
// norm_rr_scheduler: REQ_N requesters share one 2-stage normalization pipeline.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake; ready is the arbiter grant gated by S1 accept
//   req_data, req_exp   : packed per-requester mantissa / exponent
//   out_valid/out_ready : result handshake; out_* are the S2 registers
//   out_data, out_exp   : normalized mantissa, adjusted exponent
//   out_id              : originating requester
//   out_zero, out_uflow : mantissa was zero / shift was limited by the exponent
// S1 registers the granted operand plus its leading-zero count; S2 shifts and adjusts.
module norm_rr_scheduler #(
    parameter int unsigned DATA_W = norm_pkg::DATA_W,
    parameter int unsigned EXP_W  = norm_pkg::EXP_W,
    parameter int unsigned REQ_N  = norm_pkg::REQ_N,
    parameter int unsigned ID_W   = $clog2(REQ_N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REQ_N-1:0]        req_valid,
    output logic [REQ_N-1:0]        req_ready,
    input  logic [REQ_N*DATA_W-1:0] req_data,
    input  logic [REQ_N*EXP_W-1:0]  req_exp,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [EXP_W-1:0]        out_exp,
    output logic [ID_W-1:0]         out_id,
    output logic                    out_zero,
    output logic                    out_uflow
);

    localparam int unsigned LZ_W = $clog2(DATA_W) + 1;

    // Same layout as norm_pkg::stage_t, sized by this instance's parameters.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [EXP_W-1:0]  exp;
        logic [ID_W-1:0]   id;
        logic [LZ_W-1:0]   lz;
    } s1_t;

    logic [REQ_N-1:0]  grant;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_valid;
    logic              s2_adv, s1_accept;
    logic [DATA_W-1:0] sel_data;
    logic [EXP_W-1:0]  sel_exp;
    logic [LZ_W-1:0]   sel_lz;

    logic              s1_valid_q, s1_valid_d;
    s1_t               s1_q, s1_d;

    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              zero_q, zero_d;
    logic              uflow_q, uflow_d;

    logic [DATA_W-1:0] norm_data;
    logic [EXP_W-1:0]  norm_exp;
    logic              norm_zero, norm_uflow;
    logic [31:0]       lz_wide, exp_wide;

    assign s2_adv    = !s2_valid_q || out_ready;
    assign s1_accept = !s1_valid_q || s2_adv;
    assign req_ready = grant & {REQ_N{s1_accept}};

    rr_arbiter #(
        .REQ_N(REQ_N),
        .ID_W (ID_W)
    ) u_arb (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req_valid),
        .advance_i(s1_accept),
        .grant_o  (grant),
        .idx_o    (grant_idx),
        .valid_o  (grant_valid)
    );

    always_comb begin
        sel_data = '0;
        sel_exp  = '0;
        for (int i = 0; i < REQ_N; i++) begin
            if (grant[i]) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
                sel_exp  = req_exp[i*EXP_W +: EXP_W];
            end
        end
    end

    leading_zero_counter #(
        .DATA_W(DATA_W),
        .LZ_W  (LZ_W)
    ) u_lzc (
        .data_i (sel_data),
        .count_o(sel_lz)
    );

    // S1: loads a new operand whenever it can accept; empties when its content moves on.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (s1_accept) begin
            s1_valid_d = grant_valid;
            if (grant_valid) begin
                s1_d.data = sel_data;
                s1_d.exp  = sel_exp;
                s1_d.id   = grant_idx;
                s1_d.lz   = sel_lz;
            end
        end
    end

    // Shift is clamped to the exponent so the exponent never goes below zero.
    always_comb begin
        lz_wide    = 32'(s1_q.lz);
        exp_wide   = 32'(s1_q.exp);
        norm_zero  = (s1_q.lz == LZ_W'(DATA_W));
        norm_data  = '0;
        norm_exp   = '0;
        norm_uflow = 1'b0;
        if (norm_zero) begin
            norm_data = '0;
        end else if (lz_wide > exp_wide) begin
            norm_data  = s1_q.data << s1_q.exp;
            norm_uflow = 1'b1;
        end else begin
            norm_data = s1_q.data << s1_q.lz;
            norm_exp  = s1_q.exp - EXP_W'(s1_q.lz);
        end
    end

    // S2: outputs only change when the downstream can take them, so they hold under stall.
    always_comb begin
        s2_valid_d = s2_valid_q;
        data_d     = data_q;
        exp_d      = exp_q;
        id_d       = id_q;
        zero_d     = zero_q;
        uflow_d    = uflow_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                data_d  = norm_data;
                exp_d   = norm_exp;
                id_d    = s1_q.id;
                zero_d  = norm_zero;
                uflow_d = norm_uflow;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            data_q     <= '0;
            exp_q      <= '0;
            id_q       <= '0;
            zero_q     <= 1'b0;
            uflow_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            data_q     <= data_d;
            exp_q      <= exp_d;
            id_q       <= id_d;
            zero_q     <= zero_d;
            uflow_q    <= uflow_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = data_q;
    assign out_exp   = exp_q;
    assign out_id    = id_q;
    assign out_zero  = zero_q;
    assign out_uflow = uflow_q;

endmodule

// File: tb/tb_norm_rr_scheduler.sv
// Bench for norm_rr_scheduler: directed literal checks plus randomized traffic compared
// every cycle against a transaction-level model (result queue + issue cycle + pointer).
module tb_norm_rr_scheduler;

    localparam int DW = 8;
    localparam int EW = 6;
    localparam int RN = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [RN-1:0]    req_valid;
    logic [RN-1:0]    req_ready;
    logic [RN*DW-1:0] req_data;
    logic [RN*EW-1:0] req_exp;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [EW-1:0]    out_exp;
    logic [IW-1:0]    out_id;
    logic             out_zero;
    logic             out_uflow;

    norm_rr_scheduler #(
        .DATA_W(DW),
        .EXP_W (EW),
        .REQ_N (RN),
        .ID_W  (IW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data (req_data),
        .req_exp  (req_exp),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_exp  (out_exp),
        .out_id   (out_id),
        .out_zero (out_zero),
        .out_uflow(out_uflow)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic          zero;
        logic          uflow;
        logic [EW-1:0] e;
        logic [DW-1:0] d;
    } res_t;

    int   total = 0;
    int   bad   = 0;
    bit   armed = 1'b0;

    // Model state: results in flight (oldest first), the cycle each was accepted, RR pointer.
    res_t mq[$];
    int   mt[$];
    int   mptr  = 0;
    int   cyc_n = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc_n);
        end
    endtask

    function automatic res_t model(input logic [DW-1:0] d, input logic [EW-1:0] e, input int id);
        res_t r;
        int   lz, sh;
        r.id = IW'(id);
        if (d == 0) begin
            r.zero = 1'b1; r.uflow = 1'b0; r.e = '0; r.d = '0;
            return r;
        end
        lz = DW - $clog2(int'(d) + 1);
        r.zero  = 1'b0;
        r.uflow = (lz > int'(e));
        sh      = r.uflow ? int'(e) : lz;
        r.d     = DW'(int'(d) << sh);
        r.e     = r.uflow ? '0 : EW'(int'(e) - lz);
        return r;
    endfunction

    // Compare process: checks at the falling edge, updates the model at the rising edge.
    int            c_g;
    bit            c_found, c_rok, c_acc, c_dlv, c_rs, c_ev;
    logic [RN-1:0] c_er;
    logic [RN-1:0] c_one;
    res_t          c_res, c_h;

    initial begin
        c_one = 1;
        forever begin
            @(negedge clk);
            if (armed) begin
                c_found = 1'b0;
                c_g     = 0;
                for (int k = 0; k < RN; k++) begin
                    if (!c_found && (((req_valid >> ((mptr + k) % RN)) & 1) != 0)) begin
                        c_found = 1'b1;
                        c_g     = (mptr + k) % RN;
                    end
                end
                // A 2-deep pipe can take a new operand unless it holds two and is stalled.
                c_rok = (mq.size() < 2) || out_ready;
                c_er  = (c_found && c_rok) ? (c_one << c_g) : '0;
                check("req_ready", 32'(req_ready), 32'(c_er));
                c_ev = (mq.size() > 0) && (mt[0] + 2 <= cyc_n);
                check("out_valid", 32'(out_valid), 32'(c_ev));
                if (c_ev) begin
                    c_h = mq[0];
                    check("out_data", 32'(out_data), 32'(c_h.d));
                    check("out_exp", 32'(out_exp), 32'(c_h.e));
                    check("out_id", 32'(out_id), 32'(c_h.id));
                    check("out_zero", 32'(out_zero), 32'(c_h.zero));
                    check("out_uflow", 32'(out_uflow), 32'(c_h.uflow));
                end
                c_acc = c_found && c_rok;
                c_dlv = c_ev && out_ready;
                c_rs  = rst;
                if (c_acc) begin
                    c_res = model(DW'(req_data >> (c_g * DW)), EW'(req_exp >> (c_g * EW)), c_g);
                end
            end
            @(posedge clk);
            if (armed) begin
                if (c_rs) begin
                    mq.delete();
                    mt.delete();
                    mptr = 0;
                end else begin
                    if (c_dlv) begin
                        void'(mq.pop_front());
                        void'(mt.pop_front());
                    end
                    if (c_acc) begin
                        mq.push_back(c_res);
                        mt.push_back(cyc_n);
                        mptr = (c_g + 1) % RN;
                    end
                end
                cyc_n++;
            end
        end
    end

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic v, input logic [DW-1:0] d,
                            input logic [EW-1:0] e);
        req_valid[i]          = v;
        req_data[i*DW +: DW]  = d;
        req_exp[i*EW +: EW]   = e;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_exp   = '0;
        out_ready = 1'b0;
        to_pos();
        to_pos();
        rst   = 1'b0;
        armed = 1'b1;
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_exp", 32'(out_exp), 0);
        check("rst_id", 32'(out_id), 0);
        check("rst_zero", 32'(out_zero), 0);
        check("rst_uflow", 32'(out_uflow), 0);

        // Basic normalize on requester 2.
        set_lane(2, 1'b1, 8'h10, 6'd10);
        out_ready = 1'b1;
        to_neg();
        check("basic_rdy", 32'(req_ready), 32'h4);
        to_pos();
        req_valid = '0;
        to_neg();
        check("basic_lat", 32'(out_valid), 0);
        to_neg();
        check("basic_valid", 32'(out_valid), 1);
        check("basic_data", 32'(out_data), 32'h80);
        check("basic_exp", 32'(out_exp), 7);
        check("basic_id", 32'(out_id), 2);
        check("basic_flags", 32'({out_zero, out_uflow}), 0);
        to_pos();

        // Round-robin fairness from a fresh pointer.
        rst = 1'b1;
        to_pos();
        rst = 1'b0;
        for (int i = 0; i < RN; i++) set_lane(i, 1'b1, DW'(8'h21 + i * 8'h13), EW'(20 + i));
        for (int k = 0; k < 10; k++) begin
            to_neg();
            if (k >= 2) begin
                check("rr_valid", 32'(out_valid), 1);
                check("rr_id", 32'(out_id), 32'((k - 2) % RN));
            end
            to_pos();
        end
        req_valid = '0;
        repeat (3) to_pos();

        // Zero and underflow, back to back on requester 1.
        set_lane(1, 1'b1, 8'h00, 6'd5);
        to_pos();
        set_lane(1, 1'b1, 8'h01, 6'd3);
        to_pos();
        req_valid = '0;
        to_neg();
        check("zero_flag", 32'(out_zero), 1);
        check("zero_data", 32'(out_data), 0);
        check("zero_exp", 32'(out_exp), 0);
        check("zero_uflow", 32'(out_uflow), 0);
        to_neg();
        check("uf_data", 32'(out_data), 32'h08);
        check("uf_exp", 32'(out_exp), 0);
        check("uf_flag", 32'(out_uflow), 1);
        check("uf_zero", 32'(out_zero), 0);
        to_pos();

        // Backpressure: fill the pipe, stall three cycles, then release.
        rst = 1'b1;
        to_pos();
        rst = 1'b0;
        for (int i = 0; i < RN; i++) set_lane(i, 1'b1, DW'(8'h05 + i * 8'h31), EW'(9 + i));
        out_ready = 1'b0;
        to_pos();
        to_pos();
        for (int k = 2; k <= 4; k++) begin
            to_neg();
            check("bp_rdy", 32'(req_ready), 0);
            check("bp_valid", 32'(out_valid), 1);
            check("bp_id", 32'(out_id), 0);
            to_pos();
        end
        out_ready = 1'b1;
        to_neg();
        check("bp_ptr_held", 32'(req_ready), 32'h4);
        check("bp_id0", 32'(out_id), 0);
        to_neg();
        check("bp_id1", 32'(out_id), 1);
        to_neg();
        check("bp_id2", 32'(out_id), 2);

        // Reset with both stages full.
        to_pos();
        rst = 1'b1;
        to_pos();
        rst = 1'b0;
        to_neg();
        check("mrst_valid", 32'(out_valid), 0);
        check("mrst_grant", 32'(req_ready), 32'h1);
        to_neg();
        check("mrst_valid2", 32'(out_valid), 0);
        to_neg();
        check("mrst_first", 32'(out_valid), 1);
        check("mrst_id", 32'(out_id), 0);
        to_pos();

        // Randomized traffic, stalls and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < RN; i++) begin
                int sel;
                logic [DW-1:0] d;
                logic [EW-1:0] e;
                sel = $urandom_range(0, 3);
                d = (sel == 0) ? '0 : (sel == 1) ? DW'($urandom_range(1, 15)) : DW'($urandom);
                e = ($urandom_range(0, 1) == 0) ? EW'($urandom_range(0, 8)) : EW'($urandom);
                set_lane(i, 1'($urandom), d, e);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            to_pos();
        end

        rst       = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
        repeat (5) to_pos();
        check("drain_empty", 32'(mq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
